// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle RV32M/RV64M multiply/divide unit beside the EXU ALU.
// One operation in flight at a time. Multiplies complete after a fixed-latency
// count. Divides run a radix-2 restoring loop on operand magnitudes and then
// apply the sign fix-up. Division by zero and signed overflow take a short path
// through DIVSPEC. The result leaves as a one-cycle writeback pulse.
module alu_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [4:0]       in_rd_addr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             busy,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       wb_rd_addr,
  output logic [TAG_W-1:0] wb_tag
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV     = 3'd2,
    S_FIX     = 3'd3,
    S_DIVSPEC = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_r, state_n_s;
  logic [2:0]        op_r;
  logic [4:0]        rd_r;
  logic [TAG_W-1:0]  tag_r;
  // quot_r holds rs1 for multiplies and the dividend/quotient shift register for divides.
  // div_r holds rs2 for multiplies and the divisor magnitude for divides.
  logic [XLEN-1:0]   quot_r, rem_r, div_r;
  logic              neg_q_r, neg_rem_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN-1:0]   wb_data_r;
  logic [4:0]        wb_rd_r;
  logic [TAG_W-1:0]  wb_tag_r;

  logic              accept_s, div_signed_s, rs1_neg_s, rs2_neg_s, spec_s;
  logic [XLEN-1:0]   rs1_abs_s, rs2_abs_s, res_s;
  logic [XLEN:0]     rem_sh_s, diff_s;
  logic              a_sign_s, b_sign_s;
  logic [2*XLEN+1:0] ma_s, mb_s, prod_s;

  assign in_ready   = (state_r == S_IDLE);
  assign busy       = (state_r != S_IDLE);
  assign wb_valid   = (state_r == S_DONE) & ~flush;
  assign wb_data    = wb_data_r;
  assign wb_rd_addr = wb_rd_r;
  assign wb_tag     = wb_tag_r;

  // Accept-time decode: handshake, operand magnitudes, special-case detection.
  always_comb begin
    accept_s     = in_valid & in_ready & ~flush;
    div_signed_s = ~in_op[0];
    rs1_neg_s    = div_signed_s & in_rs1[XLEN-1];
    rs2_neg_s    = div_signed_s & in_rs2[XLEN-1];
    rs1_abs_s    = rs1_neg_s ? -in_rs1 : in_rs1;
    rs2_abs_s    = rs2_neg_s ? -in_rs2 : in_rs2;
    spec_s       = (in_rs2 == '0) | (div_signed_s & (in_rs1 == MIN_V) & (in_rs2 == '1));
  end

  // Restoring divide step and sign-extended full-width multiply.
  always_comb begin
    rem_sh_s = {rem_r, quot_r[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, div_r};
    a_sign_s = (op_r != 3'd3) & quot_r[XLEN-1];
    b_sign_s = (op_r == 3'd1) & div_r[XLEN-1];
    ma_s     = {{(XLEN+2){a_sign_s}}, quot_r};
    mb_s     = {{(XLEN+2){b_sign_s}}, div_r};
    prod_s   = ma_s * mb_s;
  end

  // Result selection for the cycle that transitions into DONE.
  always_comb begin
    res_s = '0;
    case (state_r)
      S_MUL: begin
        if (op_r == 3'd0) res_s = prod_s[XLEN-1:0];
        else              res_s = prod_s[2*XLEN-1:XLEN];
      end
      S_FIX: begin
        if (op_r[1]) res_s = neg_rem_r ? -rem_r  : rem_r;
        else         res_s = neg_q_r   ? -quot_r : quot_r;
      end
      S_DIVSPEC: begin
        if (op_r[1]) res_s = rem_r;
        else         res_s = quot_r;
      end
      default: res_s = '0;
    endcase
  end

  // Next-state logic; flush returns any busy state to IDLE.
  always_comb begin
    state_n_s = state_r;
    if (flush && (state_r != S_IDLE)) begin
      state_n_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!accept_s)      state_n_s = S_IDLE;
          else if (!in_op[2]) state_n_s = S_MUL;
          else if (spec_s)    state_n_s = S_DIVSPEC;
          else                state_n_s = S_DIV;
        end
        S_MUL: begin
          if (cnt_r == '0) state_n_s = S_DONE;
          else             state_n_s = S_MUL;
        end
        S_DIV: begin
          if (cnt_r == '0) state_n_s = S_FIX;
          else             state_n_s = S_DIV;
        end
        S_FIX:     state_n_s = S_DONE;
        S_DIVSPEC: state_n_s = S_DONE;
        S_DONE:    state_n_s = S_IDLE;
        default:   state_n_s = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_n_s;
  end

  // Operand capture at accept, multiply countdown, and divide iterations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 3'd0;
      rd_r      <= 5'd0;
      tag_r     <= '0;
      quot_r    <= '0;
      rem_r     <= '0;
      div_r     <= '0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= '0;
    end else if (accept_s) begin
      op_r      <= in_op;
      rd_r      <= in_rd_addr;
      tag_r     <= in_tag;
      neg_q_r   <= rs1_neg_s ^ rs2_neg_s;
      neg_rem_r <= rs1_neg_s;
      if (!in_op[2]) begin
        quot_r <= in_rs1;
        rem_r  <= '0;
        div_r  <= in_rs2;
        cnt_r  <= CNT_W'(MUL_LAT - 1);
      end else if (spec_s) begin
        quot_r <= (in_rs2 == '0) ? '1 : in_rs1;
        rem_r  <= (in_rs2 == '0) ? in_rs1 : '0;
        div_r  <= in_rs2;
        cnt_r  <= '0;
      end else begin
        quot_r <= rs1_abs_s;
        rem_r  <= '0;
        div_r  <= rs2_abs_s;
        cnt_r  <= CNT_W'(XLEN - 1);
      end
    end else if (state_r == S_MUL) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else if (state_r == S_DIV) begin
      cnt_r <= cnt_r - CNT_W'(1);
      if (!diff_s[XLEN]) begin
        rem_r  <= diff_s[XLEN-1:0];
        quot_r <= {quot_r[XLEN-2:0], 1'b1};
      end else begin
        rem_r  <= rem_sh_s[XLEN-1:0];
        quot_r <= {quot_r[XLEN-2:0], 1'b0};
      end
    end
  end

  // Writeback registers load on entry to DONE and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_r <= '0;
      wb_rd_r   <= 5'd0;
      wb_tag_r  <= '0;
    end else if (state_n_s == S_DONE) begin
      wb_data_r <= res_s;
      wb_rd_r   <= rd_r;
      wb_tag_r  <= tag_r;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (XLEN=32, MUL_LAT=2).
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_tag;
  logic        flush;
  logic        busy;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_tag;

  int n_checks = 0;
  int n_errors = 0;
  int wb_cnt   = 0;

  alu_muldiv #(.XLEN(32), .MUL_LAT(2), .TAG_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_addr(in_rd_addr),
    .in_tag(in_tag), .flush(flush), .busy(busy), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_tag(wb_tag)
  );

  always #5 clk = ~clk;

  // Count every writeback pulse the DUT emits.
  always @(posedge clk) begin
    if (wb_valid) wb_cnt <= wb_cnt + 1;
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Present one operation from a negedge; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] tag);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("ready_timeout", 64'(in_ready), 64'd1);
    in_op = op; in_rs1 = a; in_rs2 = b; in_rd_addr = rd; in_tag = tag;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_rs1 = 32'hDEAD_BEEF; in_rs2 = 32'hDEAD_BEEF; in_op = 3'd0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int  lat = 0;
    bit  got = 1'b0;
    bit  rdy_bad = 1'b0;
    issue(op, a, b, rd, tag);
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      lat = i;
      if (wb_valid) got = 1'b1;
      else if (in_ready) rdy_bad = 1'b1;
    end
    check_eq({name, "_valid"}, 64'(got), 64'd1);
    check_eq({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({name, "_data"}, 64'(wb_data), 64'(exp));
    check_eq({name, "_rd"}, 64'(wb_rd_addr), 64'(rd));
    check_eq({name, "_tag"}, 64'(wb_tag), 64'(tag));
    check_eq({name, "_rdy_low"}, 64'(rdy_bad), 64'd0);
    @(negedge clk);
    check_eq({name, "_pulse"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    int c0, c1;
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rs1 = '0; in_rs2 = '0;
    in_rd_addr = 5'd0; in_tag = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_wbv", 64'(wb_valid), 64'd0);
    check_eq("rst_data", 64'(wb_data), 64'd0);
    check_eq("rst_rd", 64'(wb_rd_addr), 64'd0);
    check_eq("rst_tag", 64'(wb_tag), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hA5A5_0001, 32'hFFFF_FFEB, 3);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hA5A5_0002, 32'hFFFF_FFFE, 3);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hA5A5_0003, 32'h0000_0000, 3);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hA5A5_0004, 32'hFFFF_FFFF, 3);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hA5A5_0005, 32'hFFFF_FFFD, 34);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hA5A5_0006, 32'hFFFF_FFFF, 34);
    run_op("divu0",  3'd5, 32'h0000_1234, 32'h0000_0000, 5'd7,  32'hA5A5_0007, 32'hFFFF_FFFF, 2);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'hA5A5_0008, 32'h0000_0000, 2);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'hA5A5_0009, 32'h8000_0000, 2);
    run_op("divu",   3'd5, 32'h0000_0064, 32'h0000_0007, 5'd10, 32'hA5A5_000A, 32'h0000_000E, 34);
    run_op("remu0rd",3'd7, 32'h0000_0064, 32'h0000_0007, 5'd0,  32'hA5A5_000B, 32'h0000_0002, 34);
    run_op("rem0",   3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd11, 32'hA5A5_000C, 32'hFFFF_FFF9, 2);

    // Flush in IDLE blocks the accept.
    c0 = wb_cnt;
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0;
    @(posedge clk);
    #1;
    check_eq("flush_idle_busy", 64'(busy), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    // Flush during DONE suppresses the pulse combinationally.
    issue(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd12, 32'hA5A5_000D);
    @(negedge clk);
    @(negedge clk);
    check_eq("done_pre_flush", 64'(wb_valid), 64'd1);
    flush = 1'b1;
    #1;
    check_eq("done_flush_wbv", 64'(wb_valid), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("done_flush_busy", 64'(busy), 64'd0);

    // Flush at divide iteration 10, then an immediate multiply.
    issue(3'd4, 32'h0000_0100, 32'h0000_0003, 5'd13, 32'hA5A5_000E);
    repeat (10) @(negedge clk);
    check_eq("div_busy_mid", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_ready", 64'(in_ready), 64'd1);
    check_eq("flush_wbv", 64'(wb_valid), 64'd0);
    run_op("mul_after_flush", 3'd0, 32'h0000_0010, 32'h0000_0003, 5'd14, 32'hA5A5_000F, 32'h0000_0030, 3);
    check_eq("flush_wb_count", 64'(wb_cnt), 64'(c0 + 1));

    // Asynchronous reset mid-divide.
    c1 = wb_cnt;
    issue(3'd4, 32'h0000_0100, 32'h0000_0003, 5'd15, 32'hA5A5_0010);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_wbv", 64'(wb_valid), 64'd0);
    check_eq("arst_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("arst_ready", 64'(in_ready), 64'd1);
    check_eq("arst_no_stale", 64'(wb_cnt), 64'(c1));
    run_op("mul_after_rst", 3'd0, 32'h0000_0009, 32'h0000_0009, 5'd16, 32'hA5A5_0011, 32'h0000_0051, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle execute ALU. Adds RV32M/RV64M multiply, divide and remainder, which need more than one cycle.
- Sits in the EXU beside the ALU and is fed from the IDU1 issue stage.
- Accepts one operation at a time under a valid/ready handshake.
- Multiplies run over a fixed-latency counter. Divides run through a radix-2 restoring iterative engine.
- Produces a one-cycle writeback pulse carrying rd address and instruction tag, in the same format as the ALU writeback.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_LAT, 2, cycles from accept to multiply result; legal 1..4.
- TAG_W, 32, width of the instruction tag carried alongside the operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  issue stage presents an operation.
- in_ready  output  1  block can accept; high only in IDLE.
- in_op  input  3  RV funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_rs1  input  XLEN  operand a.
- in_rs2  input  XLEN  operand b.
- in_rd_addr  input  5  destination register.
- in_tag  input  TAG_W  instruction tag.
- flush  input  1  abort any in-flight operation.
- busy  output  1  high in any state other than IDLE.
- wb_valid  output  1  one-cycle result pulse; the consumer cannot stall it.
- wb_data  output  XLEN  result.
- wb_rd_addr  output  5  destination register of the result.
- wb_tag  output  TAG_W  tag of the result.

Behaviour:
- Accept condition: in_valid & in_ready at a rising edge. Operands, op, rd_addr and tag are captured into internal registers. Inputs are don't-care after capture.
- States and transitions:
  - IDLE: on accept, go to MUL if op<4. Otherwise go to DIVSPEC if rs2==0 or the signed-overflow case applies. Otherwise go to DIV.
  - MUL: counter loads MUL_LAT-1 and decrements; at 0, go to DONE.
  - DIV: XLEN iterations, one quotient bit per cycle, on magnitudes. Signed ops take absolute values at accept. Counter loads XLEN-1; at 0, go to FIX.
  - FIX: negate quotient if operand signs differ (DIV). Negate remainder if rs1 is negative (REM). Then go to DONE.
  - DIVSPEC: go to DONE.
  - DONE: wb_valid=1 for this cycle only; go to IDLE.
- Latency, counted in cycles from the accept edge to wb_valid:
  - MUL: MUL_LAT+1.
  - DIV: XLEN+2.
  - DIVSPEC: 2.
  - Back-to-back issue is possible: the next accept can occur in the cycle after DONE.
- Multiply results: full 2*XLEN product with sign handling per op.
  - MUL returns the low XLEN bits.
  - MULH uses signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned; each returns the high XLEN bits.
- Divide special cases (RISC-V defined):
  - rs2==0: quotient is all ones; remainder is rs1.
  - Signed rs1 = -2^(XLEN-1) with rs2 = -1: quotient is rs1; remainder is 0.
  - DIVU and REMU by zero follow the same rs2==0 rule.
- Flush:
  - In any non-IDLE state, the next state is IDLE and no wb_valid is produced. This includes DONE: wb_valid is suppressed combinationally that cycle.
  - flush in IDLE with in_valid=1 blocks the accept.
- Reset: asynchronous; state goes to IDLE. in_ready=1 after reset. busy, wb_valid, wb_data, wb_rd_addr and wb_tag are 0, as are all internal registers.
- Outputs:
  - wb_data, wb_rd_addr and wb_tag are registered and hold their last value outside DONE.
  - A write with rd_addr=0 is still reported; the register file discards it.

Test Plan:
- XLEN=32, MUL_LAT=2. Issue MUL with rs1=0x0000_0007, rs2=0xFFFF_FFFD -> wb_valid 3 cycles after accept, wb_data=0xFFFF_FFEB, tag echoed.
- Issue MULHU with rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> wb_data=0xFFFF_FFFE. Issue MULH with the same operands -> 0x0000_0000. Issue MULHSU with the same operands -> 0xFFFF_FFFF.
- Issue DIV with rs1=-7 (0xFFFF_FFF9), rs2=2 -> wb_valid exactly 34 cycles after accept, wb_data=0xFFFF_FFFD. Then issue REM with the same operands -> 0xFFFF_FFFF. in_ready=0 throughout both.
- Issue DIVU with rs2=0 -> wb_data=0xFFFF_FFFF at cycle 2. Issue REM with rs1=0x8000_0000, rs2=0xFFFF_FFFF -> wb_data=0 at cycle 2. Issue DIV with the same operands -> 0x8000_0000.
- Start DIV, assert flush at iteration 10 -> no wb_valid, in_ready=1 next cycle. Then issue MUL immediately -> correct result.
- Assert rst mid-DIV, asynchronous to clk -> busy and wb_valid drop immediately, in_ready=1 after release, no stale wb_valid.
